// File: rtl/io_pkg.sv
// Shared types and default constants for the receive-side pad conditioner.
// The FSM encoding is deliberately two-bit one-hot so that the two unused codes
// (00 and 11) exist and can be steered back to STABLE.
package io_pkg;

    // Conditioner FSM: idle-and-settled, or qualifying a candidate level change.
    typedef enum logic [1:0] {
        STABLE  = 2'b01,
        CONFIRM = 2'b10
    } io_cond_state_e;

    // Defaults used by the conditioner and its synchroniser.
    localparam int IO_SYNC_STAGES_DEF = 2;
    localparam int IO_DEBOUNCE_DEF    = 16;

endpackage : io_pkg

// File: rtl/io_sync_chain.sv
// Multi-flop synchroniser for a single asynchronous bit.
// Every stage resets to RESET_LEVEL so the downstream debouncer sees a settled,
// known level during and immediately after reset.
module io_sync_chain
    import io_pkg::*;
#(
    parameter int   STAGES      = IO_SYNC_STAGES_DEF,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw input one stage further into the clock domain each cycle.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Synchroniser flops, forced to the reset level while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_LEVEL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule : io_sync_chain

// File: rtl/io_input_conditioner.sv
// Receive-side pad conditioner: synchronise, debounce, and report a clean level
// with single-cycle rise/fall pulses.
//
// Optional feature: define IO_GLITCH_CNT_EN to add the glitch_cnt output, a
// saturating count of candidate transitions that were abandoned before being
// accepted. Without the macro the port and its counter do not exist.
//
// A new level must be seen on the synchroniser output for DEBOUNCE_CYCLES
// consecutive clock edges before out follows it. The edge that accepts the level
// also registers rise or fall, so the pulse sits in the same cycle as the new out.
module io_input_conditioner
    import io_pkg::*;
#(
    parameter int   SYNC_STAGES     = IO_SYNC_STAGES_DEF,
    parameter int   DEBOUNCE_CYCLES = IO_DEBOUNCE_DEF,
    parameter logic RESET_LEVEL     = 1'b0,
    parameter int   GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in,
    output logic                out,
    output logic                rise,
    output logic                fall,
    output logic                busy
`ifdef IO_GLITCH_CNT_EN
    ,
    output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    // Value held by cnt on the edge that accepts the new level.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Reject illegal configurations at elaboration time.
    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || GLITCH_W < 1) begin : g_param_check
        $error("io_input_conditioner: illegal parameter value");
    end

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic sync_s;

    io_sync_chain #(
        .STAGES      (SYNC_STAGES),
        .RESET_LEVEL (RESET_LEVEL)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (in),
        .q     (sync_s)
    );

    // ------------------------------------------------------------------
    // Debounce FSM, qualification counter and edge pulses
    // ------------------------------------------------------------------
    io_cond_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             mismatch;
    logic             toggle;

    // The synchronised input disagrees with the currently reported level.
    assign mismatch = (sync_s != out_q);

    // Next-state, counter and pulse decode; defaults hold state and clear pulses.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        toggle  = 1'b0;
        case (state_q)
            STABLE: begin
                cnt_d = '0;
                if (mismatch) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        // A single disagreeing sample is already enough.
                        toggle = 1'b1;
                    end else begin
                        state_d = CONFIRM;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            CONFIRM: begin
                if (!mismatch) begin
                    // Input fell back before qualifying: drop the candidate.
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    toggle  = 1'b1;
                    state_d = STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                // Unused encodings recover to the settled state.
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase

        out_d  = toggle ? ~out_q : out_q;
        rise_d = toggle & ~out_q;
        fall_d = toggle &  out_q;
    end

    // FSM, counter, level and pulse registers; reset leaves no pulse behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            out_q   <= RESET_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign out  = out_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = (state_q == CONFIRM);

`ifdef IO_GLITCH_CNT_EN
    // ------------------------------------------------------------------
    // Glitch counter: one count per abandoned qualification, saturating.
    // ------------------------------------------------------------------
    logic [GLITCH_W-1:0] glitch_q, glitch_d;
    logic                glitch_abort;

    assign glitch_abort = (state_q == CONFIRM) && !mismatch;

    // Increment on each abort, holding at all-ones instead of wrapping.
    always_comb begin
        glitch_d = glitch_q;
        if (glitch_abort && (glitch_q != {GLITCH_W{1'b1}})) begin
            glitch_d = glitch_q + GLITCH_W'(1);
        end
    end

    // Glitch count register, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign glitch_cnt = glitch_q;
`endif

endmodule : io_input_conditioner
